// File: rtl/snake_engine.sv
// snake_engine: movement and collision engine for the snake game.
// Holds the body as a coordinate shift register (seg[0] is the head),
// advances it on each step tick, grows on food, and flags win / crash.
// Also answers the display path's per-cell "is this body" query.
module snake_engine #(
    parameter int GRID_W          = 16,
    parameter int GRID_H          = 16,
    parameter int MAX_BODY_LENGTH = 32,
    parameter int INIT_LENGTH     = 3,
    localparam int CW = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H),
    localparam int LW = $clog2(MAX_BODY_LENGTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic          up_button,
    input  logic          right_button,
    input  logic          down_button,
    input  logic          left_button,
    input  logic [CW-1:0] food_x,
    input  logic [CW-1:0] food_y,
    input  logic [CW-1:0] pix_x,
    input  logic [CW-1:0] pix_y,
    output logic [CW-1:0] head_x,
    output logic [CW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          ate,
    output logic          won,
    output logic          crashed,
    output logic          pix_body
);

    // Encoding chosen so the reverse of a direction is dir ^ 2.
    typedef enum logic [1:0] {UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3} dir_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD, S_WON} state_t;

    state_t state_q, state_d;
    dir_t   dir_q, pending_q, pending_d;

    logic [CW-1:0] seg_x [MAX_BODY_LENGTH];
    logic [CW-1:0] seg_y [MAX_BODY_LENGTH];
    logic [LW-1:0] length_q;
    logic          ate_q, won_q, crashed_q;

    logic          running, do_step;
    logic [CW-1:0] nh_x, nh_y;
    logic          wall_hit, self_hit, grow, crash, reach_max;
    logic [LW-1:0] length_p1, hit_limit;

    assign head_x  = seg_x[0];
    assign head_y  = seg_y[0];
    assign length  = length_q;
    assign ate     = ate_q;
    assign won     = won_q;
    assign crashed = crashed_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: start always (re)enters RUN; steps only matter in RUN
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN && step) begin
            if (crash)
                state_d = S_DEAD;
            else if (grow && reach_max)
                state_d = S_WON;
        end
    end

    // FSM outputs: a step is only honoured in RUN and never alongside start
    always_comb begin
        running = (state_q == S_RUN);
        do_step = running && step && !start;
    end

    // Direction latch: later assignments win, so up has the highest priority
    always_comb begin
        pending_d = pending_q;
        if (left_button  && dir_q != RIGHT) pending_d = LEFT;
        if (down_button  && dir_q != UP)    pending_d = DOWN;
        if (right_button && dir_q != LEFT)  pending_d = RIGHT;
        if (up_button    && dir_q != DOWN)  pending_d = UP;
    end

    // Next head cell and wall check; nh may wrap when wall_hit, but is then unused
    always_comb begin
        nh_x     = seg_x[0];
        nh_y     = seg_y[0];
        wall_hit = 1'b0;
        unique case (pending_q)
            UP: begin
                wall_hit = (seg_y[0] == '0);
                nh_y     = seg_y[0] - CW'(1);
            end
            DOWN: begin
                wall_hit = (seg_y[0] == CW'(GRID_H - 1));
                nh_y     = seg_y[0] + CW'(1);
            end
            LEFT: begin
                wall_hit = (seg_x[0] == '0);
                nh_x     = seg_x[0] - CW'(1);
            end
            default: begin
                wall_hit = (seg_x[0] == CW'(GRID_W - 1));
                nh_x     = seg_x[0] + CW'(1);
            end
        endcase
    end

    // Growth and self collision; the tail cell is legal only when it vacates
    always_comb begin
        grow      = (nh_x == food_x) && (nh_y == food_y);
        length_p1 = length_q + LW'(1);
        reach_max = (length_p1 == LW'(MAX_BODY_LENGTH));
        hit_limit = grow ? length_q : length_q - LW'(1);
        self_hit  = 1'b0;
        for (int i = 0; i < MAX_BODY_LENGTH; i++) begin
            if (LW'(i) < hit_limit && seg_x[i] == nh_x && seg_y[i] == nh_y)
                self_hit = 1'b1;
        end
        crash = wall_hit || self_hit;
    end

    // Display query against the live segments only
    always_comb begin
        pix_body = 1'b0;
        for (int i = 0; i < MAX_BODY_LENGTH; i++) begin
            if (LW'(i) < length_q && seg_x[i] == pix_x && seg_y[i] == pix_y)
                pix_body = 1'b1;
        end
    end

    // Body, direction and status registers; start re-initialises like reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_BODY_LENGTH; i++) begin
                seg_x[i] <= (i < INIT_LENGTH) ? CW'(GRID_W / 2 - i) : '0;
                seg_y[i] <= CW'(GRID_H / 2);
            end
            dir_q     <= RIGHT;
            pending_q <= RIGHT;
            length_q  <= LW'(INIT_LENGTH);
            ate_q     <= 1'b0;
            won_q     <= 1'b0;
            crashed_q <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < MAX_BODY_LENGTH; i++) begin
                seg_x[i] <= (i < INIT_LENGTH) ? CW'(GRID_W / 2 - i) : '0;
                seg_y[i] <= CW'(GRID_H / 2);
            end
            dir_q     <= RIGHT;
            pending_q <= RIGHT;
            length_q  <= LW'(INIT_LENGTH);
            ate_q     <= 1'b0;
            won_q     <= 1'b0;
            crashed_q <= 1'b0;
        end else begin
            ate_q <= 1'b0;
            if (running)
                pending_q <= pending_d;
            if (do_step) begin
                if (crash) begin
                    crashed_q <= 1'b1;
                end else begin
                    for (int i = MAX_BODY_LENGTH - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= nh_x;
                    seg_y[0] <= nh_y;
                    dir_q    <= pending_q;
                    if (grow) begin
                        length_q <= length_p1;
                        ate_q    <= 1'b1;
                        if (reach_max)
                            won_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: default 16x16 grid instance plus a
// MAX_BODY_LENGTH=5 instance for the win condition.
module tb_snake_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, step, start5, step5;
    logic       up_b, right_b, down_b, left_b;
    logic [3:0] food_x, food_y, food5_x, food5_y, pix_x, pix_y;

    logic [3:0] head_x, head_y, head5_x, head5_y;
    logic [5:0] length;
    logic [2:0] length5;
    logic       ate, won, crashed, pix_body;
    logic       ate5, won5, crashed5, pix_body5;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    snake_engine dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .up_button(up_b), .right_button(right_b), .down_button(down_b), .left_button(left_b),
        .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
        .head_x(head_x), .head_y(head_y), .length(length),
        .ate(ate), .won(won), .crashed(crashed), .pix_body(pix_body)
    );

    snake_engine #(.MAX_BODY_LENGTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .step(step5),
        .up_button(1'b0), .right_button(1'b0), .down_button(1'b0), .left_button(1'b0),
        .food_x(food5_x), .food_y(food5_y), .pix_x(pix_x), .pix_y(pix_y),
        .head_x(head5_x), .head_y(head5_y), .length(length5),
        .ate(ate5), .won(won5), .crashed(crashed5), .pix_body(pix_body5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Hold {up,right,down,left} for one non-step cycle
    task automatic press(input logic [3:0] b);
        {up_b, right_b, down_b, left_b} = b;
        tick();
        {up_b, right_b, down_b, left_b} = 4'b0000;
    endtask

    task automatic chk_head(input string tag, input int x, input int y);
        chk({tag, ".x"}, 32'(head_x), 32'(x));
        chk({tag, ".y"}, 32'(head_y), 32'(y));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; start5 = 1'b0; step5 = 1'b0;
        {up_b, right_b, down_b, left_b} = 4'b0000;
        food_x = 4'd0; food_y = 4'd0; food5_x = 4'd0; food5_y = 4'd0;
        pix_x = 4'd0; pix_y = 4'd0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk_head("rst_head", 8, 8);
        chk("rst_len", 32'(length), 3);
        chk("rst_flags", {ate, won, crashed}, 0);
        pix_x = 4'd6; pix_y = 4'd8; #1;
        chk("rst_pix_tail", 32'(pix_body), 1);
        pix_x = 4'd5; #1;
        chk("rst_pix_out", 32'(pix_body), 0);

        // Steps are ignored in IDLE
        do_step();
        chk_head("idle_step", 8, 8);

        // Straight run, no food
        do_start();
        do_step(); chk_head("run1", 9, 8);
        do_step(); chk_head("run2", 10, 8);
        do_step(); chk_head("run3", 11, 8);
        chk("run_len", 32'(length), 3);
        chk("run_ate", 32'(ate), 0);

        // Turn up, reverse ignored, then down+left picks left
        do_start();
        press(4'b1000); do_step(); chk_head("turn_up", 8, 7);
        press(4'b0010); do_step(); chk_head("rev_ignored", 8, 6);
        press(4'b0011); do_step(); chk_head("prio_left", 7, 6);

        // Eat food in front
        do_start();
        food_x = 4'd9; food_y = 4'd8;
        do_step();
        food_x = 4'd0; food_y = 4'd0;
        chk_head("eat", 9, 8);
        chk("eat_len", 32'(length), 4);
        chk("eat_ate", 32'(ate), 1);
        pix_x = 4'd6; pix_y = 4'd8; #1;
        chk("eat_pix_tail", 32'(pix_body), 1);
        pix_x = 4'd5; #1;
        chk("eat_pix_out", 32'(pix_body), 0);

        // U-turn into the vacating tail cell is legal
        press(4'b1000); do_step();
        chk("ate_one_cycle", 32'(ate), 0);
        chk_head("u1", 9, 7);
        press(4'b0001); do_step(); chk_head("u2", 8, 7);
        press(4'b0010); do_step(); chk_head("u3", 8, 8);
        chk("u_crash", 32'(crashed), 0);
        chk("u_len", 32'(length), 4);

        // Same path, food on the tail cell: tail stays, so it is a crash
        do_start();
        food_x = 4'd9; food_y = 4'd8; do_step();
        food_x = 4'd0; food_y = 4'd0;
        press(4'b1000); do_step();
        press(4'b0001); do_step();
        food_x = 4'd8; food_y = 4'd8;
        press(4'b0010); do_step();
        food_x = 4'd0; food_y = 4'd0;
        chk("self_crash", 32'(crashed), 1);
        chk_head("self_head", 8, 7);
        chk("self_len", 32'(length), 4);
        chk("self_ate", 32'(ate), 0);

        // Start and step together: step dropped
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        chk_head("start_step", 8, 8);
        chk("start_clr_crash", 32'(crashed), 0);

        // Right wall
        for (int i = 0; i < 7; i++) do_step();
        chk_head("at_wall", 15, 8);
        chk("at_wall_crash", 32'(crashed), 0);
        do_step();
        chk("wall_crash", 32'(crashed), 1);
        chk_head("wall_head", 15, 8);
        press(4'b0010); do_step(); do_step();
        chk_head("dead_frozen", 15, 8);
        chk("dead_sticky", 32'(crashed), 1);
        do_start();
        chk_head("restart", 8, 8);
        chk("restart_len", 32'(length), 3);
        chk("restart_crash", 32'(crashed), 0);

        // Asynchronous reset mid-run, then back in IDLE
        do_step();
        chk_head("pre_rst", 9, 8);
        #2 rst = 1'b1;
        #1 chk_head("async_rst", 8, 8);
        tick();
        rst = 1'b0;
        tick();
        do_step();
        chk_head("post_rst_idle", 8, 8);

        // Win on the small instance
        start5 = 1'b1; tick(); start5 = 1'b0;
        food5_x = 4'd9; food5_y = 4'd8;
        step5 = 1'b1; tick(); step5 = 1'b0;
        chk("w_len4", 32'(length5), 4);
        chk("w_won_early", 32'(won5), 0);
        food5_x = 4'd10;
        step5 = 1'b1; tick(); step5 = 1'b0;
        chk("w_len5", 32'(length5), 5);
        chk("w_won", 32'(won5), 1);
        chk("w_ate", 32'(ate5), 1);
        chk("w_head", 32'(head5_x), 10);
        food5_x = 4'd0; food5_y = 4'd0;
        step5 = 1'b1; tick(); tick(); step5 = 1'b0;
        chk("w_frozen", 32'(head5_x), 10);
        chk("w_sticky", 32'(won5), 1);
        chk("w_crash", 32'(crashed5), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
